// File: rtl/modulo_buffer_principal_rolhas_pkg.sv
// rtl/modulo_buffer_principal_rolhas_pkg.sv - shared state codes and default limits for the main cork reservoir
package modulo_buffer_principal_rolhas_pkg;

    localparam int DEFAULT_WIDTH        = 7;
    localparam int DEFAULT_MAX_ROLHAS   = 99;
    localparam int DEFAULT_MIN_ROLHAS   = 5;
    localparam int DEFAULT_TRANSFER_MAX = 15;
    localparam int DEFAULT_INIT_ROLHAS  = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_FILL = 2'b01,
        ST_ACK  = 2'b10
    } state_t;

endpackage

// File: rtl/modulo_buffer_principal_rolhas_if.sv
// rtl/modulo_buffer_principal_rolhas_if.sv - transfer handshake between secondary stage and main reservoir
interface modulo_buffer_principal_rolhas_if
    import modulo_buffer_principal_rolhas_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);
    logic             transfer_req;
    logic [WIDTH-1:0] transfer_qtd;
    logic             transfer_ack;
    logic [WIDTH-1:0] transfer_aceito;

    modport master (
        output transfer_req,
        output transfer_qtd,
        input  transfer_ack,
        input  transfer_aceito
    );

    modport slave (
        input  transfer_req,
        input  transfer_qtd,
        output transfer_ack,
        output transfer_aceito
    );
endinterface

// File: rtl/modulo_buffer_principal_rolhas_contador.sv
// rtl/modulo_buffer_principal_rolhas_contador.sv - up/down cork counter with synchronous clear, saturating at zero
module modulo_contador_sync_7_bits_up_down_sat
    import modulo_buffer_principal_rolhas_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int INIT  = DEFAULT_INIT_ROLHAS
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             inc,
    input  logic             dec,
    output logic [WIDTH-1:0] count
);

    // A decrement at zero is dropped, so inc+dec at zero still nets +1.
    always_ff @(posedge clk) begin
        if (clr) begin
            count <= WIDTH'(INIT);
        end else begin
            unique case ({inc, dec})
                2'b10: count <= count + WIDTH'(1);
                2'b01: if (count != '0) count <= count - WIDTH'(1);
                2'b11: if (count == '0) count <= count + WIDTH'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/modulo_buffer_principal_rolhas.sv
// rtl/modulo_buffer_principal_rolhas.sv - main cork reservoir: transfer FSM, clamp, pending counter and seal consumption
module modulo_buffer_principal_rolhas
    import modulo_buffer_principal_rolhas_pkg::*;
#(
    parameter int WIDTH        = DEFAULT_WIDTH,
    parameter int MAX_ROLHAS   = DEFAULT_MAX_ROLHAS,
    parameter int MIN_ROLHAS   = DEFAULT_MIN_ROLHAS,
    parameter int TRANSFER_MAX = DEFAULT_TRANSFER_MAX,
    parameter int INIT_ROLHAS  = DEFAULT_INIT_ROLHAS
) (
    input  logic                                     clk,
    input  logic                                     clr,
    input  logic                                     enable,
    input  logic                                     seal_pulse,
    modulo_buffer_principal_rolhas_if.slave          bus,
    output logic [WIDTH-1:0]                         reg_r,
    output logic                                     ro,
    output logic                                     min_signal,
    output logic [1:0]                               estado
);

    state_t           state;
    logic [WIDTH-1:0] pending;
    logic [WIDTH-1:0] accepted;
    logic             ack;
    logic [WIDTH-1:0] aceito;
    logic [WIDTH-1:0] room;
    logic [WIDTH-1:0] clamp;
    logic             fill_step;

    // Headroom clamp keeps reg_r <= MAX_ROLHAS, so the counter never wraps.
    always_comb begin
        room  = WIDTH'(MAX_ROLHAS) - reg_r;
        clamp = bus.transfer_qtd;
        if (clamp > WIDTH'(TRANSFER_MAX)) clamp = WIDTH'(TRANSFER_MAX);
        if (clamp > room)                 clamp = room;
    end

    assign fill_step = (state == ST_FILL) && enable && (pending != '0);

    always_ff @(posedge clk) begin
        if (clr) begin
            state    <= ST_IDLE;
            pending  <= '0;
            accepted <= '0;
            ack      <= 1'b0;
            aceito   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.transfer_req && enable) begin
                        accepted <= clamp;
                        pending  <= clamp;
                        if (clamp != '0) begin
                            state <= ST_FILL;
                        end else begin
                            state  <= ST_ACK;
                            ack    <= 1'b1;
                            aceito <= '0;
                        end
                    end
                end
                ST_FILL: begin
                    if (pending == '0) begin
                        state  <= ST_ACK;
                        ack    <= 1'b1;
                        aceito <= accepted;
                    end else if (enable) begin
                        pending <= pending - WIDTH'(1);
                    end
                end
                ST_ACK: begin
                    // Waiting for req to drop guarantees one transfer per request.
                    if (!bus.transfer_req) begin
                        state  <= ST_IDLE;
                        ack    <= 1'b0;
                        aceito <= '0;
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    pending <= '0;
                    ack     <= 1'b0;
                    aceito  <= '0;
                end
            endcase
        end
    end

    modulo_contador_sync_7_bits_up_down_sat #(
        .WIDTH (WIDTH),
        .INIT  (INIT_ROLHAS)
    ) u_contador (
        .clk   (clk),
        .clr   (clr),
        .inc   (fill_step),
        .dec   (seal_pulse),
        .count (reg_r)
    );

    assign bus.transfer_ack    = ack;
    assign bus.transfer_aceito = aceito;
    assign estado              = state;
    assign ro                  = (reg_r == '0);
    assign min_signal          = (reg_r < WIDTH'(MIN_ROLHAS));

endmodule

// File: tb/tb_modulo_buffer_principal_rolhas.sv
// tb/tb_modulo_buffer_principal_rolhas.sv - directed scoreboard bench for the main cork reservoir
module tb_modulo_buffer_principal_rolhas;

    localparam int W    = 7;
    localparam int MAXR = 99;
    localparam int TMAX = 15;

    logic         clk = 1'b0;
    logic         clr = 1'b1;
    logic         enable = 1'b1;
    logic         seal_pulse = 1'b0;
    logic [W-1:0] reg_r;
    logic         ro;
    logic         min_signal;
    logic [1:0]   estado;

    int vectors = 0;
    int miscompares = 0;
    int exp_count = 0;
    int sb[$];

    modulo_buffer_principal_rolhas_if #(.WIDTH(W)) bus ();

    modulo_buffer_principal_rolhas dut (
        .clk        (clk),
        .clr        (clr),
        .enable     (enable),
        .seal_pulse (seal_pulse),
        .bus        (bus),
        .reg_r      (reg_r),
        .ro         (ro),
        .min_signal (min_signal),
        .estado     (estado)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        vectors++;
        assert (reg_r <= W'(MAXR)) else begin
            miscompares++;
            $error("FAIL reg_r_bound observed=%0d expected<=%0d", reg_r, MAXR);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic do_clr();
        clr = 1'b1;
        bus.transfer_req = 1'b0;
        seal_pulse = 1'b0;
        enable = 1'b1;
        tick();
        clr = 1'b0;
        sb.delete();
        exp_count = 0;
    endtask

    // Called just after the request-sampling edge; waits for ack and retires one scoreboard entry.
    task automatic finish_transfer(input int exp_cycles);
        int n = 0;
        int exp_acc;
        while (bus.transfer_ack !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        if (bus.transfer_ack !== 1'b1) begin
            check("ack_timeout", 32'd0, 32'd1);
            sb.delete();
        end else begin
            if (sb.size() == 0) begin
                check("scoreboard_empty", 32'd0, 32'd1);
                exp_acc = 0;
            end else begin
                exp_acc = sb.pop_front();
            end
            check("aceito", bus.transfer_aceito, exp_acc);
            check("ack_latency", n, exp_cycles);
            check("estado_ack", estado, 2);
            check("reg_r_at_ack", reg_r, exp_count);
            tick();
            check("ack_held_no_restart", {estado, bus.transfer_ack}, {2'b10, 1'b1});
            bus.transfer_req = 1'b0;
            tick();
            check("idle_after_drop", {estado, bus.transfer_ack, bus.transfer_aceito}, 10'd0);
        end
    endtask

    task automatic run_transfer(input int qtd);
        int acc;
        acc = qtd;
        if (acc > TMAX) acc = TMAX;
        if (acc > MAXR - exp_count) acc = MAXR - exp_count;
        sb.push_back(acc);
        bus.transfer_qtd = W'(qtd);
        bus.transfer_req = 1'b1;
        tick();
        bus.transfer_qtd = ~W'(qtd);
        exp_count += acc;
        finish_transfer(acc == 0 ? 0 : acc + 1);
    endtask

    initial begin
        bus.transfer_req = 1'b0;
        bus.transfer_qtd = '0;
        tick();
        do_clr();
        check("reset_outputs", {reg_r, ro, min_signal, estado, bus.transfer_ack}, {7'd0, 1'b1, 1'b1, 2'b00, 1'b0});
        tick();
        check("idle_stable", {reg_r, estado}, 9'd0);

        run_transfer(20);
        check("min_after_15", {ro, min_signal}, 2'b00);
        for (int i = 0; i < 5; i++) run_transfer(15);
        check("reg_r_90", reg_r, 90);
        run_transfer(15);
        check("reg_r_99", reg_r, 99);
        run_transfer(3);
        check("reg_r_full_hold", reg_r, 99);

        do_clr();
        sb.push_back(10);
        bus.transfer_qtd = W'(10);
        bus.transfer_req = 1'b1;
        tick();
        bus.transfer_qtd = '0;
        for (int i = 0; i < 10; i++) begin
            seal_pulse = (i == 0 || i == 4 || i == 7);
            if (!(seal_pulse && exp_count > 0)) exp_count++;
            tick();
            seal_pulse = 1'b0;
            if (i == 0) check("seal_dropped_at_zero", reg_r, 1);
        end
        finish_transfer(1);
        check("reg_r_after_seals", reg_r, 8);
        seal_pulse = 1'b1;
        tick();
        seal_pulse = 1'b0;
        check("seal_idle", reg_r, 7);

        do_clr();
        seal_pulse = 1'b1;
        tick();
        seal_pulse = 1'b0;
        check("seal_at_zero", {reg_r, ro}, {7'd0, 1'b1});

        enable = 1'b0;
        bus.transfer_req = 1'b1;
        bus.transfer_qtd = W'(8);
        tick();
        tick();
        check("req_ignored_disabled", {reg_r, estado}, 9'd0);
        sb.push_back(8);
        enable = 1'b1;
        tick();
        tick();
        tick();
        check("fill_two", reg_r, 2);
        enable = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("frozen", {reg_r, estado}, {7'd2, 2'b01});
        end
        enable = 1'b1;
        exp_count = 8;
        finish_transfer(7);

        do_clr();
        bus.transfer_qtd = W'(10);
        bus.transfer_req = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) tick();
        check("mid_fill_reg", {reg_r, estado}, {7'd4, 2'b01});
        clr = 1'b1;
        tick();
        check("clr_mid_fill", {estado, reg_r, bus.transfer_ack, bus.transfer_aceito, ro}, {2'b00, 7'd0, 1'b0, 7'd0, 1'b1});
        clr = 1'b0;
        bus.transfer_req = 1'b0;
        tick();
        exp_count = 0;
        run_transfer(7);
        check("after_clr_transfer", reg_r, 7);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
